rk_step_sequencer: RTL and testbench
====================================

# rk_step_sequencer

Control stage of the Runge-Kutta solver that walks the independent variable t from t0 to t_end in steps of h. For each step it issues a request/acknowledge handshake to the RK4 datapath, then advances t and counts steps. It decides whether to continue by comparing the registered t against t_end through a comparator_nb instance, whose EQ/LT/GT outputs it consumes directly.

## Interface
Parameters:
- N, 32, signed width of t0, t_end, h, t_cur (two's complement, fixed-point scaling irrelevant here)
- C, 16, width of step counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- t0  input  N  signed start value, latched on accepted start
- t_end  input  N  signed end value, latched on accepted start
- h  input  N  signed step size, latched on accepted start
- step_req  output  1  high while waiting for datapath to complete the current step
- step_ack  input  1  datapath completed step; meaningful only while step_req=1
- t_cur  output  N  current t; stable throughout REQ
- step_count  output  C  steps completed in this run
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of run
- err  output  1  sticky error flag, cleared on next accepted start

## Operation
- One clock; reset is asynchronous and active-high.
- States: IDLE, CHECK, REQ, ADVANCE, DONE.
- IDLE: when start=1, latch t_cur<=t0, t_end_r<=t_end, h_r<=h, step_count<=0, err<=0, and go to CHECK.
- CHECK: the comparator is fed A=t_cur, B=t_end_r.
  - If h_r<=0: set err=1 and go to DONE.
  - Else if LT: go to REQ.
  - Else (EQ or GT): go to DONE.
- REQ: step_req=1. When step_ack=1 is sampled, go to ADVANCE. Otherwise stay.
- ADVANCE: compute an N+1-bit signed sum t_cur+h_r.
  - On positive overflow: t_cur<=2^(N-1)-1, err<=1, go to DONE.
  - Otherwise: t_cur<=sum[N-1:0], step_count<=step_count+1 (saturates at 2^C-1, no error), go to CHECK.
- DONE: done=1 for exactly this cycle, then go to IDLE. t_cur, step_count and err hold until the next accepted start.
- start is ignored outside IDLE. step_ack is ignored outside REQ.
- The final t_cur may exceed t_end_r by less than h_r. There is no step trimming.
- Reset values: state=IDLE, t_cur=0, step_count=0, step_req=0, busy=0, done=0, err=0; t_end_r and h_r are also 0.
- Reset asserted mid-run aborts immediately and step_req drops asynchronously. The datapath must treat that as cancellation.

## Timing
- start accepted at edge E0 → CHECK in cycle 1 → step_req high from cycle 2 (first-step latency is 2 cycles).
- Acknowledge sampled at edge Ea → ADVANCE in the next cycle → CHECK → step_req re-asserted 3 cycles after Ea. There is a minimum of 2 idle cycles between requests.
- step_req falls in the cycle after ack is sampled. Holding step_ack high continuously yields one step per 3 cycles.
- When t0>=t_end at start: DONE in cycle 2, done pulse in cycle 2, step_count=0, step_req never asserted.
- busy rises the cycle after accepted start and falls the cycle after DONE.
- All outputs are registered except step_req and busy, which are decoded from the state register (glitch-free, one-hot or binary state).

## Structure
- Shared package rk_pkg holds:
  - state enum (IDLE, CHECK, REQ, ADVANCE, DONE)
  - default widths N_DEF=32, C_DEF=16
  - constant T_MAX = 2^(N-1)-1
- One sub-module: comparator_nb #(.n(N)), instantiated once; its GT output is unused except in assertions.
- Adder overflow detection: sign bits of operands equal and sum sign differs.

## Test plan
- t0=0, t_end=10, h=2, ack returned 1 cycle after each req → exactly 5 req/ack pairs, t_cur=10, step_count=5, done pulse, err=0.
- t0=0, t_end=10, h=3 → 4 steps, final t_cur=12, err=0.
- t0=5, t_end=5 (and t0=7, t_end=5) → no step_req, done in cycle 2 after start, step_count=0.
- h=0 and h=-1 → err=1, no step_req, done pulse, t_cur=t0.
- t0=0x7FFFFFF0, t_end=0x7FFFFFFF, h=0x20 → one step, then t_cur=0x7FFFFFFF, err=1, done.
- Reset asserted while step_req=1 in step 3 → all outputs 0 immediately. A new start after reset runs cleanly from step_count=0. A start pulsed while busy has no effect.

Source files
------------

// File: rtl/rk_pkg.sv
`default_nettype none
// ============================================================================
// Module : rk_pkg
// Brief  : Shared types and constants for the Runge-Kutta step sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package rk_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_REQ     = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int N_DEF = 32;
  localparam int C_DEF = 16;

  // Largest positive two's-complement value for an n-bit word (n <= 64)
  function automatic logic [63:0] t_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  localparam logic [N_DEF-1:0] T_MAX = N_DEF'(t_max(N_DEF));

endpackage
`default_nettype wire

// File: rtl/comparator_nb.sv
`default_nettype none
// ============================================================================
// Module : comparator_nb
// Brief  : Signed n-bit magnitude comparator with EQ/LT/GT outputs.
// Rev    : 1.0  initial release
// ============================================================================
module comparator_nb #(
  parameter int n = 32
) (
  input  logic signed [n-1:0] a,
  input  logic signed [n-1:0] b,
  output logic                eq,
  output logic                lt,
  output logic                gt
);

  // Pure combinational compare of two signed operands
  always_comb begin
    eq = (a == b);
    lt = (a < b);
    gt = (a > b);
  end

endmodule
`default_nettype wire

// File: rtl/rk_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module : rk_step_sequencer
// Brief  : Walks t from t0 to t_end in steps of h, issuing one req/ack
//          handshake per step to the RK4 datapath and counting steps.
// Rev    : 1.0  initial release
// ============================================================================
module rk_step_sequencer
  import rk_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int C = C_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] t0,
  input  logic signed [N-1:0] t_end,
  input  logic signed [N-1:0] h,
  output logic                step_req,
  input  logic                step_ack,
  output logic signed [N-1:0] t_cur,
  output logic [C-1:0]        step_count,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [N-1:0] T_MAX_N = N'(t_max(N));

  state_t              state_q, state_d;
  logic signed [N-1:0] t_cur_q, t_cur_d;
  logic signed [N-1:0] t_end_q, t_end_d;
  logic signed [N-1:0] h_q, h_d;
  logic [C-1:0]        step_count_q, step_count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                cmp_eq, cmp_lt, cmp_gt;
  logic signed [N:0]   sum;
  logic                h_nonpos;
  logic                ovf;
  logic                pos_ovf;

  // Registered t_cur is always compared against the latched end value
  comparator_nb #(.n(N)) u_cmp (
    .a  (t_cur_q),
    .b  (t_end_q),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  // Step adder with sign-bit overflow detection; sum[N] tells the direction
  always_comb begin
    sum      = {t_cur_q[N-1], t_cur_q} + {h_q[N-1], h_q};
    h_nonpos = h_q[N-1] | (h_q == '0);
    ovf      = (t_cur_q[N-1] == h_q[N-1]) && (sum[N-1] != t_cur_q[N-1]);
    pos_ovf  = ovf & ~sum[N];
  end

  // Next-state and datapath register update
  always_comb begin
    state_d      = state_q;
    t_cur_d      = t_cur_q;
    t_end_d      = t_end_q;
    h_d          = h_q;
    step_count_d = step_count_q;
    err_d        = err_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          t_cur_d      = t0;
          t_end_d      = t_end;
          h_d          = h;
          step_count_d = '0;
          err_d        = 1'b0;
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A non-positive step would never reach t_end
        if (h_nonpos) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cmp_lt) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (step_ack) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (pos_ovf) begin
          t_cur_d = T_MAX_N;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          t_cur_d = sum[N-1:0];
          if (step_count_q != '1) begin
            step_count_d = step_count_q + C'(1);
          end
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done is registered so it is high exactly while in DONE
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      t_cur_q      <= '0;
      t_end_q      <= '0;
      h_q          <= '0;
      step_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_cur_q      <= t_cur_d;
      t_end_q      <= t_end_d;
      h_q          <= h_d;
      step_count_q <= step_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // step_req and busy decode straight from the state register
  always_comb begin
    step_req   = (state_q == ST_REQ);
    busy       = (state_q != ST_IDLE);
    t_cur      = t_cur_q;
    step_count = step_count_q;
    done       = done_q;
    err        = err_q;
  end

  // The comparator must always report exactly one relation
  a_cmp_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot({cmp_eq, cmp_lt, cmp_gt}));

endmodule
`default_nettype wire

// File: tb/tb_rk_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_rk_step_sequencer
// Brief  : Directed, table-driven self-checking bench for rk_step_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rk_step_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] t0, t_end, h;
  logic               step_req;
  logic               step_ack;
  logic signed [31:0] t_cur;
  logic [15:0]        step_count;
  logic               busy, done, err;

  int total = 0;
  int bad   = 0;

  rk_step_sequencer #(.N(32), .C(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .t0         (t0),
    .t_end      (t_end),
    .h          (h),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .t_cur      (t_cur),
    .step_count (step_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] t0;
    logic signed [31:0] t_end;
    logic signed [31:0] h;
    int                 exp_reqs;
    int                 exp_count;
    logic signed [31:0] exp_t;
    logic               exp_err;
    int                 exp_done_cyc;  // <=0: not checked
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One run: start, answer each request one cycle late, then check results
  task automatic run_case(input vec_t v, input bit hold_start, input string tag);
    int  cyc;
    int  reqs;
    int  dones;
    int  done_cyc;
    int  seen;
    bit  finished;
    logic signed [31:0] t_hold;
    cyc = 0; reqs = 0; dones = 0; done_cyc = 0; seen = 0; finished = 1'b0;
    t_hold = '0;
    t0 = v.t0; t_end = v.t_end; h = v.h; start = 1'b1;
    tick();
    cyc = 1;
    if (hold_start) begin
      t0 = 32'sd1234; t_end = 32'sd9999; h = 32'sd1;
    end else begin
      start = 1'b0;
    end
    chk({tag, " busy_rise"}, 64'(busy), 64'd1);
    while (!finished && cyc < 400) begin
      if (done) begin
        dones++;
        done_cyc = cyc;
        start    = 1'b0;
        finished = 1'b1;
      end
      if (step_req) begin
        if (seen == 0) begin
          seen   = 1;
          t_hold = t_cur;
        end else begin
          chk({tag, " t_cur_stable"}, 64'(t_cur), 64'(t_hold));
          seen     = 2;
          step_ack = 1'b1;
        end
      end else if (seen != 0) begin
        reqs++;
        seen     = 0;
        step_ack = 1'b0;
      end
      if (!finished) begin
        tick();
        cyc++;
      end
    end
    if (!finished) chk({tag, " timeout"}, 64'd0, 64'd1);
    tick();
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " busy_fall"}, 64'(busy), 64'd0);
    chk({tag, " reqs"}, 64'(reqs), 64'(v.exp_reqs));
    chk({tag, " step_count"}, 64'(step_count), 64'(v.exp_count));
    chk({tag, " t_cur"}, 64'(t_cur), 64'(v.exp_t));
    chk({tag, " err"}, 64'(err), 64'(v.exp_err));
    if (v.exp_done_cyc > 0) chk({tag, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done_cyc));
  endtask

  initial begin
    int rises;
    int guard;
    logic prev_req;

    tv[0] = '{32'sd0,   32'sd10, 32'sd2,  5, 5, 32'sd10, 1'b0, -1};
    tv[1] = '{32'sd0,   32'sd10, 32'sd3,  4, 4, 32'sd12, 1'b0, -1};
    tv[2] = '{32'sd5,   32'sd5,  32'sd1,  0, 0, 32'sd5,  1'b0,  2};
    tv[3] = '{32'sd7,   32'sd5,  32'sd1,  0, 0, 32'sd7,  1'b0,  2};
    tv[4] = '{32'sd0,   32'sd10, 32'sd0,  0, 0, 32'sd0,  1'b1,  2};
    tv[5] = '{32'sd3,   32'sd10, -32'sd1, 0, 0, 32'sd3,  1'b1,  2};
    tv[6] = '{32'sh7FFFFFF0, 32'sh7FFFFFFF, 32'sh20, 1, 0, 32'sh7FFFFFFF, 1'b1, -1};
    tv[7] = '{-32'sd10, -32'sd4, 32'sd2,  3, 3, -32'sd4, 1'b0, -1};

    reset = 1'b1; start = 1'b0; step_ack = 1'b0;
    t0 = '0; t_end = '0; h = '0;
    tick();
    tick();
    chk("rst step_req", 64'(step_req), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst t_cur", 64'(t_cur), 64'd0);
    chk("rst step_count", 64'(step_count), 64'd0);
    #2 reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_case(tv[i], 1'b0, $sformatf("v%0d", i));
      tick();
    end

    // start held high with junk operands while busy must not disturb the run
    run_case(tv[0], 1'b1, "hold_start");
    tick();

    // Reset while step_req is high in step 3
    t0 = 32'sd0; t_end = 32'sd10; h = 32'sd2; start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0; guard = 0; prev_req = 1'b0;
    while (rises < 3 && guard < 100) begin
      if (step_req && !prev_req) rises++;
      prev_req = step_req;
      if (rises < 3) begin
        step_ack = step_req;
        tick();
        guard++;
      end
    end
    chk("mid reqs_reached", 64'(rises), 64'd3);
    chk("mid req_before_reset", 64'(step_req), 64'd1);
    step_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid step_req", 64'(step_req), 64'd0);
    chk("mid busy", 64'(busy), 64'd0);
    chk("mid t_cur", 64'(t_cur), 64'd0);
    chk("mid step_count", 64'(step_count), 64'd0);
    chk("mid err", 64'(err), 64'd0);
    chk("mid done", 64'(done), 64'd0);
    tick();
    #2 reset = 1'b0;
    tick();
    run_case(tv[0], 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
